clk_en_div_chain: RTL and testbench
===================================

// Module: clk_en_div_chain
// PURPOSE
//  Parametrised cascade of decimal clock dividers in pure logic, no PLLs: one fabric clock in,
//  STAGES divided rates out.
//  Each stage divides the previous one by DIV and emits two outputs:
//   - a one-cycle clock-enable tick
//   - a 50%-duty square wave
//  Defaults give 500 kHz / 5 kHz / 50 Hz / 0.5 Hz from 50 MHz.
//  Sits at the top of the timing tree; downstream logic stays on clk_50MHz and qualifies with tick[k].
// PARAMETERS
//  STAGES  4    number of cascaded divider stages (>=1)
//  DIV     100  divide ratio per stage; must be even and >=2 (odd or <2 = fatal elaboration error)
//  CNT_W   clog2(DIV) per-stage counter width; derived, do not override
// PORTS
//  clk_50MHz  in   1       single system clock; all logic on rising edge
//  rst        in   1       asynchronous, active-low reset (0 = reset)
//  en         in   1       1 = run; 0 = freeze all counters, ticks forced 0, clk_out held
//  clr        in   1       synchronous clear of whole chain; dominates en
//  tick       out  STAGES  tick[k]: 1-cycle pulse, period DIV^(k+1) clk cycles
//  clk_out    out  STAGES  clk_out[k]: 50% square wave, period DIV^(k+1) clk cycles
// BEHAVIOUR
//  Reset (rst=0, async): all counters=0, tick=0, clk_out=0; state held until rst=1.
//  Advance enables:
//   - adv[0] = en
//   - adv[k] = en & tick[k-1]   (tick is registered)
//  Per stage k, each rising edge:
//   - clr=1: cnt[k]<=0, tick[k]<=0, clk_out[k]<=0 for all k
//   - else if adv[k] & cnt[k]==DIV-1: cnt[k]<=0, tick[k]<=1
//   - else if adv[k]: cnt[k]<=cnt[k]+1, tick[k]<=0
//   - else: cnt[k] holds, tick[k]<=0
//  clk_out[k] toggles on edges where adv[k]=1 and cnt[k] is DIV/2-1 or DIV-1.
//   - Result: high DIV^(k+1)/2 cycles, low DIV^(k+1)/2 cycles.
//   - First rising edge of clk_out[k] is at the same edge as the midpoint count.
//  Latency:
//   - en held 1 from edge 1 after reset/clr release
//   - tick[k] first high in the cycle after edge DIV^(k+1)+k
//   - subsequent ticks every DIV^(k+1) edges
//  Cascade skew: stage k lags stage k-1 by exactly one clk cycle (registered tick); it is constant.
//  Boundaries:
//   - Wrap: counters never exceed DIV-1; no out-of-range values reachable.
//   - All stages wrapping together (cnt = DIV-1 everywhere): each stage ticks one cycle after the
//     previous; no pulse lost.
//   - en falls while tick=1: tick drops next edge; it is not re-issued. The counter resumes from
//     its held value when en returns.
//   - clr and wrap on the same edge: clr wins; no tick is produced.
//   - rst mid-period: immediate async clear; no partial pulse completes.
//  All outputs are registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  CLKDIV_SIM_FAST_EN defined:
//   - adds input port 'fast' (1 bit), placed after clr
//   - fast=1: every stage divides by 2 instead of DIV (tick[k] period 2^(k+1)), for short sims
//   - fast changes take effect at the next edge; counters >=1 wrap to 0 on the next advance
//  CLKDIV_SIM_FAST_EN undefined: no 'fast' port; ratio is fixed at DIV; no extra logic.
// TESTING (STAGES=4, DIV=10 unless noted)
//  1. rst=0 for 3 cycles, then rst=1, en=1:
//     tick[0] pulses at edges 10,20,..; tick[1] first at edge 101, then every 100;
//     tick[3] first at edge 10003.
//  2. clk_out[0] over 40 cycles: exact 5-high/5-low pattern.
//     clk_out[2]: 500/500 duty, checked with cycle counter.
//  3. en=0 for 7 cycles starting mid-count (cnt[0]=4): outputs frozen, tick=0.
//     On resume, the next tick[0] arrives 6 enabled cycles later.
//  4. clr=1 on the edge where cnt[0..1]=9: no tick; all counters and clk_out become 0.
//     Sequence restarts as in test 1.
//  5. Assert rst=0 asynchronously mid-cycle at cnt[0]=7:
//     all outputs 0 immediately, before the next edge.
//  6. CLKDIV_SIM_FAST_EN, fast=1: tick[0] every 2 cycles, tick[3] every 16 cycles.
//     Toggle fast to 0: the DIV=10 periods return after at most one partial period.

Source files
------------

// File: rtl/clk_en_div_chain.sv
// Cascade of even-ratio dividers producing a one-cycle tick and a 50% square wave per stage.
// Optional build macro CLKDIV_SIM_FAST_EN adds a 'fast' input that forces every stage to divide by 2.
module clk_en_div_chain #(
  parameter int STAGES = 4,
  parameter int DIV    = 100
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
`ifdef CLKDIV_SIM_FAST_EN
  input  logic              fast,
`endif
  output logic [STAGES-1:0] tick,
  output logic [STAGES-1:0] clk_out
);

  localparam int CNT_W = $clog2(DIV);

  if ((DIV < 2) || ((DIV % 2) != 0)) begin : g_bad_div
    $fatal(1, "clk_en_div_chain: DIV must be even and >= 2");
  end

  if (STAGES < 1) begin : g_bad_stages
    $fatal(1, "clk_en_div_chain: STAGES must be >= 1");
  end

  logic [CNT_W-1:0]  cnt [STAGES];
  logic [STAGES-1:0] adv;

`ifdef CLKDIV_SIM_FAST_EN
  // Using >= for the wrap test lets counters left above 1 by the slow ratio fall back to 0.
  logic [CNT_W-1:0] last_cnt;
  logic [CNT_W-1:0] half_cnt;

  assign last_cnt = fast ? CNT_W'(1) : CNT_W'(DIV - 1);
  assign half_cnt = fast ? '0        : CNT_W'(DIV / 2 - 1);
`else
  localparam logic [CNT_W-1:0] last_cnt = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] half_cnt = CNT_W'(DIV / 2 - 1);
`endif

  // Each stage advances on the registered tick of the one below, so skew is one cycle per stage.
  always_comb begin
    adv    = '0;
    adv[0] = en;
    for (int k = 1; k < STAGES; k++) begin
      adv[k] = en & tick[k-1];
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) begin
        cnt[k] <= '0;
      end
      tick    <= '0;
      clk_out <= '0;
    end else if (clr) begin
      for (int k = 0; k < STAGES; k++) begin
        cnt[k] <= '0;
      end
      tick    <= '0;
      clk_out <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          if (cnt[k] >= last_cnt) begin
            cnt[k]  <= '0;
            tick[k] <= 1'b1;
          end else begin
            cnt[k]  <= cnt[k] + CNT_W'(1);
            tick[k] <= 1'b0;
          end
          // Toggling at the midpoint and at the wrap gives an exact 50% duty cycle.
          if ((cnt[k] == half_cnt) || (cnt[k] >= last_cnt)) begin
            clk_out[k] <= ~clk_out[k];
          end
        end else begin
          tick[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_en_div_chain.sv
// Directed self-checking bench for clk_en_div_chain with STAGES=4, DIV=10.
// Expected tick/clk_out values come from closed-form period formulas; the fast test needs CLKDIV_SIM_FAST_EN.
module tb_clk_en_div_chain;

  logic       clk_50MHz;
  logic       rst;
  logic       en;
  logic       clr;
`ifdef CLKDIV_SIM_FAST_EN
  logic       fast;
`endif
  logic [3:0] tick;
  logic [3:0] clk_out;

  int compared_cnt   = 0;
  int mismatched_cnt = 0;
  int hi_run         = 0;

  clk_en_div_chain #(
    .STAGES(4),
    .DIV   (10)
  ) dut (
    .clk_50MHz(clk_50MHz),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
`ifdef CLKDIV_SIM_FAST_EN
    .fast     (fast),
`endif
    .tick     (tick),
    .clk_out  (clk_out)
  );

  initial clk_50MHz = 1'b0;
  always #5 clk_50MHz = ~clk_50MHz;

  task automatic checkOutput(input string tag, input int got, input int exp);
    compared_cnt++;
    if (got !== exp) begin
      mismatched_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive inputs just after an edge, take the next edge, then sample 1 time unit later.
  task automatic applyStimulus(input logic en_v, input logic clr_v);
    en  = en_v;
    clr = clr_v;
    @(posedge clk_50MHz);
    #1;
  endtask

  // Stage k with ratio base has period base^(k+1) and first ticks on edge base^(k+1)+k.
  function automatic logic [3:0] exp_tick(input int n, input int base);
    int p;
    exp_tick = '0;
    p = base;
    for (int k = 0; k < 4; k++) begin
      if ((n > k) && (((n - k) % p) == 0)) exp_tick[k] = 1'b1;
      p = p * base;
    end
  endfunction

  function automatic logic [3:0] exp_clk(input int n, input int base);
    int p;
    exp_clk = '0;
    p = base;
    for (int k = 0; k < 4; k++) begin
      if ((n >= k) && ((((n - k) / (p / 2)) % 2) == 1)) exp_clk[k] = 1'b1;
      p = p * base;
    end
  endfunction

  task automatic check_edge(input int n, input int base);
    checkOutput($sformatf("tick@%0d", n), int'(tick), int'(exp_tick(n, base)));
    checkOutput($sformatf("clk_out@%0d", n), int'(clk_out), int'(exp_clk(n, base)));
  endtask

  task automatic run_checked(input int count, input int base);
    for (int n = 1; n <= count; n++) begin
      applyStimulus(1'b1, 1'b0);
      check_edge(n, base);
    end
  endtask

  task automatic restart_chain();
    applyStimulus(1'b1, 1'b1);
    checkOutput("clr_tick", int'(tick), 0);
    checkOutput("clr_clk_out", int'(clk_out), 0);
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    clr = 1'b0;
`ifdef CLKDIV_SIM_FAST_EN
    fast = 1'b0;
`endif

    // Reset held for three edges.
    repeat (3) @(posedge clk_50MHz);
    #1;
    checkOutput("reset_tick", int'(tick), 0);
    checkOutput("reset_clk_out", int'(clk_out), 0);

    // Free run through the first tick of the last stage, plus clk_out[2] high-time.
    rst = 1'b1;
    for (int n = 1; n <= 10003; n++) begin
      applyStimulus(1'b1, 1'b0);
      check_edge(n, 10);
      if (clk_out[2]) begin
        hi_run++;
      end else if (hi_run > 0) begin
        checkOutput("clk2_high_run", hi_run, 500);
        hi_run = 0;
      end
    end

    // Freeze at cnt[0]=4, then resume; tick[0] is due 6 enabled edges later.
    restart_chain();
    run_checked(4, 10);
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("frozen_tick%0d", i), int'(tick), 0);
      checkOutput($sformatf("frozen_clk%0d", i), int'(clk_out), 0);
    end
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("resume_tick%0d", i), int'(tick), (i == 6) ? 1 : 0);
      checkOutput($sformatf("resume_clk%0d", i), int'(clk_out), (i == 6) ? 0 : 1);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("tick_drop_on_en_low", int'(tick), 0);

    // Clear on the edge where cnt[0] and cnt[1] are both 9.
    restart_chain();
    run_checked(99, 10);
    applyStimulus(1'b1, 1'b1);
    checkOutput("clr_wrap_tick", int'(tick), 0);
    checkOutput("clr_wrap_clk_out", int'(clk_out), 0);
    run_checked(101, 10);

    // Asynchronous reset mid-cycle at cnt[0]=7.
    restart_chain();
    run_checked(7, 10);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_tick", int'(tick), 0);
    checkOutput("async_rst_clk_out", int'(clk_out), 0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rst_hold_clk_out", int'(clk_out), 0);
    rst = 1'b1;
    run_checked(20, 10);

`ifdef CLKDIV_SIM_FAST_EN
    // Divide-by-2 mode, then back to DIV=10.
    begin
      int gap;
      bit found;
      fast = 1'b1;
      restart_chain();
      run_checked(40, 2);
      fast  = 1'b0;
      found = 1'b0;
      for (int i = 1; i <= 12 && !found; i++) begin
        applyStimulus(1'b1, 1'b0);
        if (tick[0]) found = 1'b1;
      end
      checkOutput("slow_first_tick_found", int'(found), 1);
      gap   = 0;
      found = 1'b0;
      for (int i = 1; i <= 20 && !found; i++) begin
        applyStimulus(1'b1, 1'b0);
        gap = i;
        if (tick[0]) found = 1'b1;
      end
      checkOutput("slow_tick0_period", gap, 10);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatched_cnt);
    $finish;
  end

endmodule
